// File: rtl/alu_share_arbiter.sv
// Round-robin sharer of one combinational ALU between two requesters.
// One operation in flight; result held until its owner accepts it.
module alu_share_arbiter #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic [3:0]    r0_aluc,
  input  logic [DW-1:0] r0_a,
  input  logic [DW-1:0] r0_b,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic [3:0]    r1_aluc,
  input  logic [DW-1:0] r1_a,
  input  logic [DW-1:0] r1_b,
  output logic          rsp0_valid,
  output logic          rsp1_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_s,
  output logic          rsp_z,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_aluc,
  input  logic [DW-1:0] alu_s,
  input  logic          alu_z,
  output logic          busy,
  output logic          grant_id,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          gid_q, gid_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [3:0]    aluc_q, aluc_d;
  logic [DW-1:0] rsp_s_q, rsp_s_d;
  logic          rsp_z_q, rsp_z_d;
  logic [CW-1:0] cnt0_q, cnt0_d;
  logic [CW-1:0] cnt1_q, cnt1_d;

  logic any_req;
  logic win;

  // Tie goes to the requester that was not served last.
  assign any_req = r0_valid | r1_valid;
  assign win     = (r0_valid & r1_valid) ? ~last_q : r1_valid;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gid_d    = gid_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    aluc_d   = aluc_q;
    rsp_s_d  = rsp_s_q;
    rsp_z_d  = rsp_z_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          r0_ready = ~win;
          r1_ready = win;
          alu_a_d  = win ? r1_a : r0_a;
          alu_b_d  = win ? r1_b : r0_b;
          aluc_d   = win ? r1_aluc : r0_aluc;
          gid_d    = win;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_s_d = alu_s;
        rsp_z_d = alu_z;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (gid_q) begin
            if (cnt1_q != '1) cnt1_d = cnt1_q + CW'(1);
          end else begin
            if (cnt0_q != '1) cnt0_d = cnt0_q + CW'(1);
          end
          last_d  = gid_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gid_q   <= 1'b0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      aluc_q  <= '0;
      rsp_s_q <= '0;
      rsp_z_q <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      aluc_q  <= aluc_d;
      rsp_s_q <= rsp_s_d;
      rsp_z_q <= rsp_z_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign rsp0_valid = (state_q == RESP) & ~gid_q;
  assign rsp1_valid = (state_q == RESP) & gid_q;
  assign rsp_s      = rsp_s_q;
  assign rsp_z      = rsp_z_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_aluc   = aluc_q;
  assign busy       = (state_q != IDLE);
  assign grant_id   = gid_q;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: transaction-level model plus
// directed scenarios and randomized traffic.
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          r0_valid, r1_valid;
  logic          r0_ready, r1_ready;
  logic [3:0]    r0_aluc, r1_aluc;
  logic [DW-1:0] r0_a, r0_b, r1_a, r1_b;
  logic          rsp0_valid, rsp1_valid, rsp_ready;
  logic [DW-1:0] rsp_s;
  logic          rsp_z;
  logic [DW-1:0] alu_a, alu_b, alu_s;
  logic [3:0]    alu_aluc;
  logic          alu_z;
  logic          busy, grant_id;
  logic [CW-1:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu_share_arbiter #(.DW(DW), .CW(CW)) dut (
    .clock(clock), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_aluc(r0_aluc),
    .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_aluc(r1_aluc),
    .r1_a(r1_a), .r1_b(r1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_ready(rsp_ready), .rsp_s(rsp_s), .rsp_z(rsp_z),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .alu_s(alu_s), .alu_z(alu_z),
    .busy(busy), .grant_id(grant_id), .cnt0(cnt0), .cnt1(cnt1)
  );

  // Combinational ALU attached to the DUT (environment, not the model).
  function automatic logic [32:0] alu_f(logic [3:0] op, logic [31:0] a,
                                        logic [31:0] b);
    logic [31:0] s;
    s = '0;
    case (op)
      4'b0000: s = a + b;
      4'b0100: s = a - b;
      4'b0001: s = a & b;
      4'b0101: s = a | b;
      4'b0010: s = a ^ b;
      4'b0110: s = b << 16;
      4'b0011: s = b << a[4:0];
      4'b0111: s = b >> a[4:0];
      4'b1111: s = $signed(b) >>> a[4:0];
      4'b1011: s = 32'($countones(a) + $countones(b));
      default: s = '0;
    endcase
    return {s, (s == 32'd0)};
  endfunction

  assign {alu_s, alu_z} = alu_f(alu_aluc, alu_a, alu_b);

  // Model: a pending operation is either executing or waiting for accept.
  bit          m_busy, m_resp, m_own, m_last;
  logic [31:0] m_a, m_b, m_s;
  logic [3:0]  m_op;
  bit          m_z;
  int          m_cnt[2];

  task automatic model_reset();
    m_busy = 0; m_resp = 0; m_own = 0; m_last = 1;
    m_a = '0; m_b = '0; m_op = '0; m_s = '0; m_z = 0;
    m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Compare every output against the model, advance one clock.
  task automatic cycle();
    bit g, w;
    #1;
    g = !m_busy && (r0_valid || r1_valid);
    w = (r0_valid && r1_valid) ? !m_last : r1_valid;
    chk("r0_ready", 32'(r0_ready), 32'(g && !w));
    chk("r1_ready", 32'(r1_ready), 32'(g && w));
    chk("rsp0_valid", 32'(rsp0_valid), 32'(m_resp && !m_own));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(m_resp && m_own));
    chk("rsp_s", rsp_s, m_s);
    chk("rsp_z", 32'(rsp_z), 32'(m_z));
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_aluc", 32'(alu_aluc), 32'(m_op));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("grant_id", 32'(grant_id), 32'(m_own));
    chk("cnt0", 32'(cnt0), 32'(m_cnt[0]));
    chk("cnt1", 32'(cnt1), 32'(m_cnt[1]));
    if (reset) begin
      model_reset();
    end else if (g) begin
      m_a = w ? r1_a : r0_a;
      m_b = w ? r1_b : r0_b;
      m_op = w ? r1_aluc : r0_aluc;
      m_own = w; m_busy = 1; m_resp = 0;
    end else if (m_busy && !m_resp) begin
      {m_s, m_z} = alu_f(m_op, m_a, m_b);
      m_resp = 1;
    end else if (m_resp && rsp_ready) begin
      if (m_cnt[m_own] < CMAX) m_cnt[m_own]++;
      m_last = m_own; m_busy = 0; m_resp = 0;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic reset_dut();
    reset = 1; r0_valid = 0; r1_valid = 0; rsp_ready = 0;
    cycle();
    reset = 0;
  endtask

  task automatic set_r0(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    r0_valid = 1; r0_aluc = op; r0_a = a; r0_b = b;
  endtask

  task automatic set_r1(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    r1_valid = 1; r1_aluc = op; r1_a = a; r1_b = b;
  endtask

  initial begin
    reset = 1; r0_valid = 0; r1_valid = 0; rsp_ready = 0;
    r0_aluc = '0; r0_a = '0; r0_b = '0;
    r1_aluc = '0; r1_a = '0; r1_b = '0;
    @(posedge clock);
    @(negedge clock);
    model_reset();
    reset_dut();
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);

    // HAMM on r0 alone
    set_r0(4'b1011, 32'h1F, 32'h3); rsp_ready = 1;
    #1 chk("hamm_ready", 32'(r0_ready), 32'd1);
    cycle();
    r0_valid = 0;
    cycle();
    chk("hamm_v", 32'(rsp0_valid), 32'd1);
    chk("hamm_s", rsp_s, 32'd7);
    chk("hamm_z", 32'(rsp_z), 32'd0);
    cycle();
    chk("hamm_cnt0", 32'(cnt0), 32'd1);
    chk("hamm_busy", 32'(busy), 32'd0);

    // Contention right after reset, then alternation
    reset_dut();
    set_r0(4'b0000, 32'd2, 32'd3);
    set_r1(4'b0100, 32'd5, 32'd5);
    rsp_ready = 1;
    cycle(); cycle();
    chk("add_v0", 32'(rsp0_valid), 32'd1);
    chk("add_s", rsp_s, 32'd5);
    chk("add_z", 32'(rsp_z), 32'd0);
    cycle();
    #1 chk("sub_ready", 32'(r1_ready), 32'd1);
    cycle(); cycle();
    chk("sub_v1", 32'(rsp1_valid), 32'd1);
    chk("sub_s", rsp_s, 32'd0);
    chk("sub_z", 32'(rsp_z), 32'd1);
    cycle();
    for (int k = 0; k < 4; k++) begin
      #1 chk("alt_r0", 32'(r0_ready), 32'(k % 2 == 0));
      repeat (3) cycle();
    end
    r0_valid = 0; r1_valid = 0;

    // Backpressure on an r1 XOR result
    reset_dut();
    set_r1(4'b0010, 32'hFFFF0000, 32'h0000FFFF);
    cycle();
    set_r0(4'b0000, 32'd1, 32'd1);
    cycle();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_s", rsp_s, 32'hFFFFFFFF);
      chk("bp_v1", 32'(rsp1_valid), 32'd1);
      chk("bp_r0_ready", 32'(r0_ready), 32'd0);
      cycle();
    end
    rsp_ready = 1;
    cycle();
    chk("bp_cnt1", 32'(cnt1), 32'd1);
    r0_valid = 0; r1_valid = 0; rsp_ready = 0;

    // Operand change after acceptance
    reset_dut();
    set_r0(4'b0110, 32'd0, 32'h1234);
    cycle();
    r0_b = '0; r0_valid = 0;
    cycle();
    chk("lui_s", rsp_s, 32'h12340000);
    rsp_ready = 1;
    cycle();

    // Reset while a response is pending
    reset_dut();
    set_r0(4'b0000, 32'd1, 32'd1);
    cycle();
    r0_valid = 0;
    cycle();
    chk("abort_pre_v0", 32'(rsp0_valid), 32'd1);
    reset = 1;
    cycle();
    reset = 0;
    chk("abort_v0", 32'(rsp0_valid), 32'd0);
    chk("abort_cnt0", 32'(cnt0), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    set_r1(4'b0001, 32'hF0F0, 32'hFF00);
    #1 chk("abort_r1_ready", 32'(r1_ready), 32'd1);
    cycle();
    r1_valid = 0;
    cycle();
    rsp_ready = 1;
    chk("abort_r1_s", rsp_s, 32'h0000F000);
    cycle();

    // Counter saturation
    reset_dut();
    rsp_ready = 1;
    set_r0(4'b0000, 32'd4, 32'd4);
    repeat (15) cycle();
    chk("sat_cnt0", 32'(cnt0), 32'd3);
    chk("sat_cnt1", 32'(cnt1), 32'd0);
    r0_valid = 0;

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      reset     = ($urandom_range(99) == 0);
      r0_valid  = ($urandom_range(2) != 0);
      r1_valid  = ($urandom_range(2) != 0);
      rsp_ready = $urandom_range(1);
      r0_aluc   = 4'($urandom);
      r1_aluc   = 4'($urandom);
      r0_a = $urandom_range(3) == 0 ? 32'($urandom_range(40)) : $urandom;
      r0_b = $urandom;
      r1_a = $urandom_range(3) == 0 ? 32'($urandom_range(40)) : $urandom;
      r1_b = $urandom_range(3) == 0 ? r1_a : $urandom;
      cycle();
    end
    reset = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Arbiter and sequencer that shares one combinational 32-bit ALU (4-bit aluc encoding, s/z outputs) between two requesters, e.g. the main datapath and a coprocessor/test engine. It grants round-robin, latches the granted operands, drives the ALU from registers, captures s/z into a result register and holds it until the owner accepts it. One operation is in flight at a time. Per-requester completion counters are kept for performance monitoring.

Parameters:
DW, 32, operand/result width; must match ALU width
CW, 16, width of each completion counter; counters saturate at all-ones

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
r0_valid  in  1  requester 0 has an operation
r0_ready  out  1  requester 0 operation accepted this cycle
r0_aluc  in  4  requester 0 ALU opcode
r0_a  in  DW  requester 0 operand a
r0_b  in  DW  requester 0 operand b
r1_valid, r1_ready, r1_aluc, r1_a, r1_b  same as r0_*, for requester 1
rsp0_valid  out  1  result for requester 0 is on rsp_s/rsp_z
rsp1_valid  out  1  result for requester 1 is on rsp_s/rsp_z
rsp_ready  in  1  owner of the current response accepts it
rsp_s  out  DW  registered ALU result
rsp_z  out  1  registered ALU zero flag
alu_a  out  DW  to ALU a, registered
alu_b  out  DW  to ALU b, registered
alu_aluc  out  4  to ALU aluc, registered
alu_s  in  DW  from ALU s
alu_z  in  1  from ALU z
busy  out  1  state != IDLE
grant_id  out  1  requester owning the current/last operation
cnt0  out  CW  completed (accepted) responses, requester 0
cnt1  out  CW  completed (accepted) responses, requester 1

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset: state IDLE, last-grant pointer = 1 (requester 0 wins first tie), grant_id=0. All outputs 0: r*_ready, rsp*_valid, rsp_s, rsp_z, alu_a, alu_b, alu_aluc, cnt0, cnt1.
- IDLE:
  - If no valid, stay.
  - If exactly one valid, grant it.
  - If both valid, grant the requester not equal to the last-grant pointer.
  - Granted rN_ready is combinational: high only in IDLE for the winner, in the cycle of grant. Never both high.
  - On grant: register a/b/aluc into alu_a/alu_b/alu_aluc, set grant_id, go to EXEC.
- EXEC (1 cycle): ALU output is combinationally stable from the registered inputs. Capture alu_s into rsp_s and alu_z into rsp_z. Go to RESP.
- RESP: rsp{grant_id}_valid=1, the other rsp valid is 0. rsp_s/rsp_z are held stable.
  - On rsp_ready: increment cnt{grant_id} (saturate at 2^CW-1), update last-grant pointer to grant_id, go to IDLE.
  - rsp_ready with no rsp valid is ignored.
- Latency: grant at cycle T, response valid at T+2. Minimum 3 cycles per operation, back-to-back.
- Opcodes are passed through unmodified, including HAMM (1011), shifts and undefined codes. The result is whatever the ALU returns (0 for undefined, z=1).
- alu_* outputs hold their last value outside EXEC; no toggling when idle.
- A requester dropping valid without ready is legal; no grant is recorded.
- reset asserted in EXEC or RESP aborts the operation: no response and no count update. The following cycle is IDLE with reset values.
- Operand changes on rN_a/b after acceptance do not affect the in-flight operation.

Test Plan:
- After reset, r0 only: aluc=1011, a=0x0000001F, b=0x00000003 -> r0_ready pulse at T; at T+2 rsp0_valid=1, rsp_s=7, rsp_z=0; rsp_ready at T+2 -> cnt0=1, busy=0 at T+3.
- Both valid right after reset: r0 ADD 2+3, r1 SUB 5-5 -> r0 granted first (rsp_s=5, z=0); r1 granted next (rsp_s=0, rsp_z=1, rsp1_valid). Both held valid repeatedly -> grants alternate 0,1,0,1.
- Response backpressure: r1 XOR 0xFFFF0000^0x0000FFFF, rsp_ready low for 5 cycles -> rsp_s=0xFFFFFFFF held, alu_* and state unchanged, no new r*_ready; accepted on cycle 6 -> cnt1 increments once.
- Operand change after accept: r0 LUI b=0x1234, then change r0_b to 0 at T+1 -> rsp_s=0x12340000.
- Reset in RESP: reset high during RESP -> next cycle rsp*_valid=0, counters 0, busy=0; the next r1 request is granted normally.
- Counter saturation (CW=2): 5 accepted r0 ops -> cnt0 sticks at 3, cnt1=0.
